// File: rtl/i2c_cfg_sequencer.sv
// i2c_cfg_sequencer: walks a {last,dev,reg,val} table, issuing 2-byte I2C writes (with ACK retries) or timed delays
module i2c_cfg_sequencer #(
  parameter int unsigned TBL_AW    = 4,
  parameter int unsigned MAX_RETRY = 3,
  parameter int unsigned DLY_UNIT  = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              done,
  output logic              error,
  output logic              busy,
  output logic [TBL_AW-1:0] tbl_addr,
  input  logic [23:0]       tbl_data,
  output logic [6:0]        cmd_address,
  output logic              cmd_start,
  output logic              cmd_read,
  output logic              cmd_write,
  output logic              cmd_write_multiple,
  output logic              cmd_stop,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [7:0]        data_tdata,
  output logic              data_tvalid,
  output logic              data_tlast,
  input  logic              data_tready,
  input  logic              i2c_busy,
  input  logic              missed_ack,
  output logic [TBL_AW-1:0] err_index,
  output logic [1:0]        retry_cnt
);
  typedef enum logic [3:0] {IDLE, FETCH, LOAD, CMD, BYTE0, BYTE1, WAIT, CHECK, DELAY, DONE, FAIL} state_t;
  state_t state_q, state_d;
  logic [TBL_AW-1:0] addr_q, addr_d, err_idx_q, err_idx_d;
  logic [23:0] ent_q, ent_d;
  logic [1:0] retry_q, retry_d, wcnt_q, wcnt_d;
  logic [31:0] dly_q, dly_d;
  logic error_q, error_d, ack_err_q, ack_err_d;
  logic last;
  assign last = ent_q[23] || (&addr_q);
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      err_idx_q <= '0;
      ent_q     <= '0;
      retry_q   <= '0;
      wcnt_q    <= '0;
      dly_q     <= '0;
      error_q   <= 1'b0;
      ack_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      err_idx_q <= err_idx_d;
      ent_q     <= ent_d;
      retry_q   <= retry_d;
      wcnt_q    <= wcnt_d;
      dly_q     <= dly_d;
      error_q   <= error_d;
      ack_err_q <= ack_err_d;
    end
  end
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    err_idx_d = err_idx_q;
    ent_d     = ent_q;
    retry_d   = retry_q;
    wcnt_d    = wcnt_q;
    dly_d     = dly_q;
    error_d   = error_q;
    ack_err_d = ack_err_q | (missed_ack && (state_q inside {CMD, BYTE0, BYTE1, WAIT}));
    case (state_q)
      IDLE: if (start) begin
        addr_d    = '0;
        err_idx_d = '0;
        retry_d   = '0;
        error_d   = 1'b0;
        ack_err_d = 1'b0;
        state_d   = FETCH;
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        ent_d     = tbl_data;
        dly_d     = 32'(tbl_data[15:0]) * DLY_UNIT;
        ack_err_d = 1'b0;
        state_d   = tbl_data[22:16] != '0 ? CMD : tbl_data[15:0] == '0 ? CHECK : DELAY;
      end
      CMD:   if (cmd_ready) state_d = BYTE0;
      BYTE0: if (data_tready) state_d = BYTE1;
      BYTE1: if (data_tready) begin
        wcnt_d  = '0;
        state_d = WAIT;
      end
      WAIT: if (wcnt_q != 2'd2) wcnt_d = wcnt_q + 2'd1;
        else if (!i2c_busy) state_d = CHECK;
      CHECK: if (!ack_err_q) begin
        retry_d = '0;
        addr_d  = last ? addr_q : addr_q + 1'b1;
        state_d = last ? DONE : FETCH;
      end else if (32'(retry_q) < MAX_RETRY) begin
        retry_d   = retry_q + 2'd1;
        ack_err_d = 1'b0;
        state_d   = CMD;
      end else begin
        err_idx_d = addr_q;
        error_d   = 1'b1;
        state_d   = FAIL;
      end
      DELAY: if (dly_q == 32'd1) state_d = CHECK;
        else dly_d = dly_q - 32'd1;
      default: state_d = IDLE;
    endcase
  end
  assign busy               = state_q != IDLE;
  assign done               = state_q == DONE;
  assign error              = error_q;
  assign tbl_addr           = addr_q;
  assign err_index          = err_idx_q;
  assign retry_cnt          = retry_q;
  assign cmd_valid          = state_q == CMD;
  assign cmd_address        = ent_q[22:16];
  assign cmd_start          = 1'b0;
  assign cmd_read           = 1'b0;
  assign cmd_write          = 1'b0;
  assign cmd_write_multiple = cmd_valid;
  assign cmd_stop           = cmd_valid;
  assign data_tvalid        = state_q inside {BYTE0, BYTE1};
  assign data_tlast         = state_q == BYTE1;
  assign data_tdata         = state_q == BYTE1 ? ent_q[7:0] : ent_q[15:8];
endmodule
